// File: rtl/axil_mem_arbiter_pkg.sv
// Shared AXI-Lite definitions for the memory-side arbiter: arbiter FSM states and
// response codes.
package axi_defines;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } axil_arb_state_t;

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_mem_arbiter_rr_pick.sv
// Two-requester grant picker, purely combinational.
// Build option AXIL_ARB_FIXED_PRIO_EN: port 0 always wins a tie and `last` is ignored.
module axil_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       any
);

    always_comb begin
        gnt = '0;
        any = |req;
`ifdef AXIL_ARB_FIXED_PRIO_EN
        if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
`else
        // On a tie the port that was not served last wins.
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
`endif
    end

endmodule

// File: rtl/axil_mem_arbiter.sv
// Two-port AXI-Lite arbiter in front of the shared SDRAM controller slave port.
// Build option AXIL_ARB_FIXED_PRIO_EN selects fixed priority (port 0) instead of round-robin.
module axil_mem_arbiter
    import axi_defines::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ADDR_WIDTH-1:0]   s0_axil_awaddr,
    input  logic [2:0]              s0_axil_awprot,
    input  logic                    s0_axil_awvalid,
    output logic                    s0_axil_awready,
    input  logic [DATA_WIDTH-1:0]   s0_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_axil_wstrb,
    input  logic                    s0_axil_wvalid,
    output logic                    s0_axil_wready,
    output logic [1:0]              s0_axil_bresp,
    output logic                    s0_axil_bvalid,
    input  logic                    s0_axil_bready,
    input  logic [ADDR_WIDTH-1:0]   s0_axil_araddr,
    input  logic [2:0]              s0_axil_arprot,
    input  logic                    s0_axil_arvalid,
    output logic                    s0_axil_arready,
    output logic [DATA_WIDTH-1:0]   s0_axil_rdata,
    output logic [1:0]              s0_axil_rresp,
    output logic                    s0_axil_rvalid,
    input  logic                    s0_axil_rready,

    input  logic [ADDR_WIDTH-1:0]   s1_axil_awaddr,
    input  logic [2:0]              s1_axil_awprot,
    input  logic                    s1_axil_awvalid,
    output logic                    s1_axil_awready,
    input  logic [DATA_WIDTH-1:0]   s1_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_axil_wstrb,
    input  logic                    s1_axil_wvalid,
    output logic                    s1_axil_wready,
    output logic [1:0]              s1_axil_bresp,
    output logic                    s1_axil_bvalid,
    input  logic                    s1_axil_bready,
    input  logic [ADDR_WIDTH-1:0]   s1_axil_araddr,
    input  logic [2:0]              s1_axil_arprot,
    input  logic                    s1_axil_arvalid,
    output logic                    s1_axil_arready,
    output logic [DATA_WIDTH-1:0]   s1_axil_rdata,
    output logic [1:0]              s1_axil_rresp,
    output logic                    s1_axil_rvalid,
    input  logic                    s1_axil_rready,

    output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
    output logic [2:0]              m_axil_awprot,
    output logic                    m_axil_awvalid,
    input  logic                    m_axil_awready,
    output logic [DATA_WIDTH-1:0]   m_axil_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axil_wstrb,
    output logic                    m_axil_wvalid,
    input  logic                    m_axil_wready,
    input  logic [1:0]              m_axil_bresp,
    input  logic                    m_axil_bvalid,
    output logic                    m_axil_bready,
    output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
    output logic [2:0]              m_axil_arprot,
    output logic                    m_axil_arvalid,
    input  logic                    m_axil_arready,
    input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
    input  logic [1:0]              m_axil_rresp,
    input  logic                    m_axil_rvalid,
    output logic                    m_axil_rready
);

    axil_arb_state_t state_q, state_d;
    logic            gnt_port_q, gnt_port_d;
    logic            gnt_is_wr_q, gnt_is_wr_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic            rr_last;
    logic            rr_update;

    logic [1:0]      wr_req, rd_req, req;
    logic [1:0]      pick_gnt;
    logic            pick_any;
    logic            pick_port;

    logic            sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
    logic            wr_addr_st, wr_resp_st, rd_addr_st, rd_data_st;
    logic            aw_open, w_open;
    logic            aw_hs, w_hs;

    always_comb begin
        wr_req    = {s1_axil_awvalid && s1_axil_wvalid, s0_axil_awvalid && s0_axil_wvalid};
        rd_req    = {s1_axil_arvalid, s0_axil_arvalid};
        req       = wr_req | rd_req;
        pick_port = pick_gnt[1];
    end

    axil_rr_pick u_pick (
        .req  (req),
        .last (rr_last),
        .gnt  (pick_gnt),
        .any  (pick_any)
    );

    always_comb begin
        if (gnt_port_q) begin
            sel_awvalid   = s1_axil_awvalid;
            sel_wvalid    = s1_axil_wvalid;
            sel_bready    = s1_axil_bready;
            sel_arvalid   = s1_axil_arvalid;
            sel_rready    = s1_axil_rready;
            m_axil_awaddr = s1_axil_awaddr;
            m_axil_awprot = s1_axil_awprot;
            m_axil_wdata  = s1_axil_wdata;
            m_axil_wstrb  = s1_axil_wstrb;
            m_axil_araddr = s1_axil_araddr;
            m_axil_arprot = s1_axil_arprot;
        end else begin
            sel_awvalid   = s0_axil_awvalid;
            sel_wvalid    = s0_axil_wvalid;
            sel_bready    = s0_axil_bready;
            sel_arvalid   = s0_axil_arvalid;
            sel_rready    = s0_axil_rready;
            m_axil_awaddr = s0_axil_awaddr;
            m_axil_awprot = s0_axil_awprot;
            m_axil_wdata  = s0_axil_wdata;
            m_axil_wstrb  = s0_axil_wstrb;
            m_axil_araddr = s0_axil_araddr;
            m_axil_arprot = s0_axil_arprot;
        end
    end

    // Channel gating: only the channel owned by the current state moves, and a
    // channel that already handshook stays closed until the next grant.
    always_comb begin
        wr_addr_st = (state_q == WR_ADDR) && gnt_is_wr_q;
        wr_resp_st = (state_q == WR_RESP) && gnt_is_wr_q;
        rd_addr_st = (state_q == RD_ADDR) && !gnt_is_wr_q;
        rd_data_st = (state_q == RD_DATA) && !gnt_is_wr_q;
        aw_open    = wr_addr_st && !aw_done_q;
        w_open     = wr_addr_st && !w_done_q;

        m_axil_awvalid = aw_open && sel_awvalid;
        m_axil_wvalid  = w_open && sel_wvalid;
        m_axil_bready  = wr_resp_st && sel_bready;
        m_axil_arvalid = rd_addr_st && sel_arvalid;
        m_axil_rready  = rd_data_st && sel_rready;

        s0_axil_awready = aw_open && !gnt_port_q && m_axil_awready;
        s1_axil_awready = aw_open &&  gnt_port_q && m_axil_awready;
        s0_axil_wready  = w_open && !gnt_port_q && m_axil_wready;
        s1_axil_wready  = w_open &&  gnt_port_q && m_axil_wready;
        s0_axil_bvalid  = wr_resp_st && !gnt_port_q && m_axil_bvalid;
        s1_axil_bvalid  = wr_resp_st &&  gnt_port_q && m_axil_bvalid;
        s0_axil_arready = rd_addr_st && !gnt_port_q && m_axil_arready;
        s1_axil_arready = rd_addr_st &&  gnt_port_q && m_axil_arready;
        s0_axil_rvalid  = rd_data_st && !gnt_port_q && m_axil_rvalid;
        s1_axil_rvalid  = rd_data_st &&  gnt_port_q && m_axil_rvalid;

        s0_axil_bresp = m_axil_bresp;
        s1_axil_bresp = m_axil_bresp;
        s0_axil_rdata = m_axil_rdata;
        s1_axil_rdata = m_axil_rdata;
        s0_axil_rresp = m_axil_rresp;
        s1_axil_rresp = m_axil_rresp;
    end

    always_comb begin
        aw_hs = m_axil_awvalid && m_axil_awready;
        w_hs  = m_axil_wvalid && m_axil_wready;
    end

    always_comb begin
        state_d     = state_q;
        gnt_port_d  = gnt_port_q;
        gnt_is_wr_d = gnt_is_wr_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rr_update   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_port_d  = pick_port;
                    gnt_is_wr_d = wr_req[pick_port];
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    state_d     = wr_req[pick_port] ? WR_ADDR : RD_ADDR;
                end
            end
            WR_ADDR: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axil_bvalid && sel_bready) begin
                    state_d   = IDLE;
                    rr_update = 1'b1;
                end
            end
            RD_ADDR: begin
                if (m_axil_arvalid && m_axil_arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_axil_rvalid && sel_rready) begin
                    state_d   = IDLE;
                    rr_update = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_port_q  <= 1'b0;
            gnt_is_wr_q <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_port_q  <= gnt_port_d;
            gnt_is_wr_q <= gnt_is_wr_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
        end
    end

`ifdef AXIL_ARB_FIXED_PRIO_EN
    always_comb begin
        rr_last = 1'b0;
    end
`else
    logic rr_last_q, rr_last_d;

    always_comb begin
        rr_last_d = rr_update ? gnt_port_q : rr_last_q;
        rr_last   = rr_last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

endmodule
